// File: rtl/scan_decoder_n.sv
// scan_decoder_n: registered one-hot column driver for the key matrix, with
// MANUAL decode of an external select and SCAN auto-sweep that samples key_in
// per column and publishes a full key map once per sweep.
// Latency: MANUAL out/cur_sel follow sel one cycle later. In SCAN, the first
//   map_valid is N*DWELL cycles after the first SCAN cycle.
// Backpressure: none. The block free-runs, and key_map/map_valid are a
//   one-cycle publish with no handshake.
// Ports: clk, reset_n (sync, active-low), enable, scan_mode, sel[SEL_W], key_in
//   -> out[N] one-hot select, cur_sel[SEL_W], key_map[N], map_valid.
module scan_decoder_n #(
  parameter int SEL_W = 3,
  parameter int DWELL = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  scan_mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  key_in,
  output logic [2**SEL_W-1:0]   out,
  output logic [SEL_W-1:0]      cur_sel,
  output logic [2**SEL_W-1:0]   key_map,
  output logic                  map_valid
);

  localparam int N     = 2**SEL_W;
  // Keep the dwell counter at least one bit wide so DWELL = 1 still elaborates.
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N - 1);
  localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MANUAL = 2'd1,
    S_SCAN   = 2'd2
  } state_t;

  state_t           r_state;
  logic [N-1:0]     r_out;
  logic [SEL_W-1:0] r_cur_sel;
  logic [N-1:0]     r_key_map;
  logic             r_map_valid;
  logic [CNT_W-1:0] r_cnt;
  logic [N-1:0]     r_shadow;

  state_t           w_state_nxt;
  logic [N-1:0]     w_out_nxt;
  logic [SEL_W-1:0] w_cur_sel_nxt;
  logic [N-1:0]     w_key_map_nxt;
  logic             w_map_valid_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [N-1:0]     w_shadow_nxt;
  logic [SEL_W-1:0] w_sel_inc;

  assign w_sel_inc = r_cur_sel + SEL_W'(1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_out       <= '0;
      r_cur_sel   <= '0;
      r_key_map   <= '0;
      r_map_valid <= 1'b0;
      r_cnt       <= '0;
      r_shadow    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_out       <= w_out_nxt;
      r_cur_sel   <= w_cur_sel_nxt;
      r_key_map   <= w_key_map_nxt;
      r_map_valid <= w_map_valid_nxt;
      r_cnt       <= w_cnt_nxt;
      r_shadow    <= w_shadow_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_out_nxt       = r_out;
    w_cur_sel_nxt   = r_cur_sel;
    w_key_map_nxt   = r_key_map;
    w_map_valid_nxt = 1'b0;
    w_cnt_nxt       = r_cnt;
    w_shadow_nxt    = r_shadow;

    if (!enable) begin
      w_state_nxt   = S_IDLE;
      w_out_nxt     = '0;
      w_cur_sel_nxt = '0;
      w_cnt_nxt     = '0;
      w_shadow_nxt  = '0;
    end else if (!scan_mode) begin
      // A partial sweep is thrown away on leaving SCAN, and key_map is kept.
      w_state_nxt   = S_MANUAL;
      w_out_nxt     = ONE_HOT0 << sel;
      w_cur_sel_nxt = sel;
      w_cnt_nxt     = '0;
      w_shadow_nxt  = '0;
    end else if (r_state != S_SCAN) begin
      // Every entry into SCAN restarts the sweep at column 0.
      w_state_nxt   = S_SCAN;
      w_out_nxt     = ONE_HOT0;
      w_cur_sel_nxt = '0;
      w_cnt_nxt     = '0;
      w_shadow_nxt  = '0;
    end else begin
      w_out_nxt = ONE_HOT0 << r_cur_sel;
      if (r_cnt != CNT_MAX) begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end else begin
        w_cnt_nxt               = '0;
        w_shadow_nxt[r_cur_sel] = key_in;
        w_cur_sel_nxt           = w_sel_inc;
        w_out_nxt               = ONE_HOT0 << w_sel_inc;
        if (r_cur_sel == SEL_LAST) begin
          // The last column is published directly from key_in on its sampling edge.
          w_key_map_nxt   = w_shadow_nxt;
          w_map_valid_nxt = 1'b1;
          w_shadow_nxt    = '0;
        end
      end
    end
  end

  assign out       = r_out;
  assign cur_sel   = r_cur_sel;
  assign key_map   = r_key_map;
  assign map_valid = r_map_valid;

endmodule

// File: tb/tb_scan_decoder_n.sv
// tb_scan_decoder_n: directed bench for scan_decoder_n. It runs two instances:
// A with SEL_W=2 and DWELL=3, and B with SEL_W=3 and DWELL=1.
// A time-based model in the bench predicts every output on each cycle, and
// literal checks pin the key points.
module tb_scan_decoder_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: SEL_W=2, DWELL=3
  logic       a_rst_n, a_en, a_scan, a_key;
  logic [1:0] a_sel;
  logic [3:0] a_out, a_map;
  logic [1:0] a_cur;
  logic       a_vld;
  logic [3:0] a_mask;

  // Instance B: SEL_W=3, DWELL=1
  logic       b_rst_n, b_en, b_scan, b_key;
  logic [2:0] b_sel;
  logic [7:0] b_out, b_map;
  logic [2:0] b_cur;
  logic       b_vld;
  logic [7:0] b_mask;

  scan_decoder_n #(.SEL_W(2), .DWELL(3)) u_a (
    .clk(clk), .reset_n(a_rst_n), .enable(a_en), .scan_mode(a_scan),
    .sel(a_sel), .key_in(a_key), .out(a_out), .cur_sel(a_cur),
    .key_map(a_map), .map_valid(a_vld));

  scan_decoder_n #(.SEL_W(3), .DWELL(1)) u_b (
    .clk(clk), .reset_n(b_rst_n), .enable(b_en), .scan_mode(b_scan),
    .sel(b_sel), .key_in(b_key), .out(b_out), .cur_sel(b_cur),
    .key_map(b_map), .map_valid(b_vld));

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: SCAN position is derived from elapsed SCAN time t.
  // The column is (t / DWELL) mod N, and sampling happens on the last cycle of
  // each dwell.
  int m_n[2]     = '{4, 8};
  int m_d[2]     = '{3, 1};
  int m_mode[2]  = '{0, 0};  // 0 idle, 1 manual, 2 scan
  int m_t[2]     = '{0, 0};
  int m_shadow[2] = '{0, 0};
  int m_out[2]   = '{0, 0};
  int m_cur[2]   = '{0, 0};
  int m_map[2]   = '{0, 0};
  int m_vld[2]   = '{0, 0};

  task automatic model_step(input int i, input bit rst_n, input bit en,
                            input bit scn, input int sel, input bit key);
    int col;
    m_vld[i] = 0;
    if (!rst_n) begin
      m_mode[i] = 0; m_t[i] = 0; m_shadow[i] = 0;
      m_out[i] = 0; m_cur[i] = 0; m_map[i] = 0;
    end else if (!en) begin
      m_mode[i] = 0; m_t[i] = 0; m_shadow[i] = 0; m_out[i] = 0; m_cur[i] = 0;
    end else if (!scn) begin
      m_mode[i] = 1; m_t[i] = 0; m_shadow[i] = 0;
      m_cur[i] = sel; m_out[i] = 1 << sel;
    end else if (m_mode[i] != 2) begin
      m_mode[i] = 2; m_t[i] = 0; m_shadow[i] = 0;
      m_cur[i] = 0; m_out[i] = 1;
    end else begin
      col = (m_t[i] / m_d[i]) % m_n[i];
      if (m_t[i] % m_d[i] == m_d[i] - 1) begin
        if (key) m_shadow[i] = m_shadow[i] | (1 << col);
        if (col == m_n[i] - 1) begin
          m_map[i] = m_shadow[i];
          m_vld[i] = 1;
          m_shadow[i] = 0;
        end
      end
      m_t[i] = m_t[i] + 1;
      m_cur[i] = (m_t[i] / m_d[i]) % m_n[i];
      m_out[i] = 1 << m_cur[i];
    end
  endtask

  always @(posedge clk) begin
    model_step(0, a_rst_n, a_en, a_scan, int'(a_sel), a_key);
    model_step(1, b_rst_n, b_en, b_scan, int'(b_sel), b_key);
  end

  // Compare process: runs every cycle once both instances have seen reset.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("a_out",     a_out, m_out[0]);
      chk("a_cur_sel", a_cur, m_cur[0]);
      chk("a_key_map", a_map, m_map[0]);
      chk("a_map_vld", a_vld, m_vld[0]);
      chk("a_onehot0", $onehot0(a_out), 1);
      chk("b_out",     b_out, m_out[1]);
      chk("b_cur_sel", b_cur, m_cur[1]);
      chk("b_key_map", b_map, m_map[1]);
      chk("b_map_vld", b_vld, m_vld[1]);
      chk("b_onehot0", $onehot0(b_out), 1);
    end
  end

  // Advance one clock. Key inputs follow the model's current column.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    a_key = a_mask[m_cur[0][1:0]];
    b_key = b_mask[m_cur[1][2:0]];
  endtask

  initial begin
    logic [3:0] exp_dec [4];
    int pulses;
    exp_dec = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    a_rst_n = 1'b0; a_en = 1'b1; a_scan = 1'b1; a_sel = '0; a_key = 1'b0; a_mask = '0;
    b_rst_n = 1'b0; b_en = 1'b0; b_scan = 1'b0; b_sel = '0; b_key = 1'b0; b_mask = '0;

    // Reset is held for two cycles while the inputs request SCAN.
    tick();
    chk_on = 1'b1;
    tick();
    chk("rst_out", a_out, 4'b0000);
    chk("rst_cur", a_cur, 2'd0);
    chk("rst_map", a_map, 4'b0000);
    chk("rst_vld", a_vld, 1'b0);

    // MANUAL decode
    a_rst_n = 1'b1; a_scan = 1'b0;
    for (int s = 0; s < 4; s++) begin
      a_sel = 2'(s);
      tick();
      chk("man_out", a_out, exp_dec[s]);
    end
    a_en = 1'b0;
    tick();
    chk("man_disable_out", a_out, 4'b0000);

    // SCAN sweep with a key pressed on column 2
    a_mask = 4'b0100;
    a_en = 1'b1; a_scan = 1'b1;
    tick();
    chk("scan_entry_out", a_out, 4'b0001);
    pulses = 0;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (a_vld) pulses++;
      if (k == 3)  chk("scan_col1_out", a_out, 4'b0010);
      if (k == 12) begin
        chk("scan_vld12", a_vld, 1'b1);
        chk("scan_map12", a_map, 4'b0100);
      end
      if (k == 24) chk("scan_vld24", a_vld, 1'b1);
    end
    chk("scan_pulses", pulses, 2);

    // Abort mid-sweep at column 1
    tick(); tick(); tick(); tick();
    chk("abort_cur1", a_cur, 2'd1);
    a_scan = 1'b0;
    tick();
    a_scan = 1'b1;
    a_mask = 4'b1001;
    tick();
    chk("abort_restart_out", a_out, 4'b0001);
    chk("abort_map_kept", a_map, 4'b0100);
    pulses = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (a_vld) pulses++;
    end
    chk("abort_fresh_map", a_map, 4'b1001);
    chk("abort_pulses", pulses, 1);

    // Reset while column 3 is driven
    for (int k = 0; k < 9; k++) tick();
    chk("midrst_cur3", a_cur, 2'd3);
    a_rst_n = 1'b0;
    tick();
    chk("midrst_out", a_out, 4'b0000);
    chk("midrst_map", a_map, 4'b0000);
    a_rst_n = 1'b1;
    tick();
    chk("midrst_resume_out", a_out, 4'b0001);
    a_en = 1'b0;

    // Instance B: DWELL=1, N=8, keys pressed on columns 0 and 7
    b_rst_n = 1'b1; b_en = 1'b1; b_scan = 1'b1; b_mask = 8'b1000_0001;
    tick();
    chk("b_entry_out", b_out, 8'h01);
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("b_adv_out", b_out, 32'(1 << (k % 8)));
      chk("b_vld_period", b_vld, (k % 8 == 0) ? 1 : 0);
      if (k == 8) chk("b_map8", b_map, 8'b1000_0001);
    end

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
